peak_offset_tracker: RTL

PEAK_OFFSET_TRACKER -- requirements
Module: peak_offset_tracker

---
 rtl/peak_offset_tracker_if.sv | 29 ++
 rtl/peak_offset_tracker.sv | 134 +++++++++++++
 2 files changed

// File: rtl/peak_offset_tracker_if.sv
// Bundles the run-control, metric stream and result signals of peak_offset_tracker.
// master drives start/metric/sym_end and observes results; slave is the tracker itself.
interface peak_offset_tracker_if #(
  parameter int MW        = 24,
  parameter int LOG2_NSYM = 2
);
  logic                 start;
  logic [12:0]          idx;
  logic                 metric_valid;
  logic [MW-1:0]        metric;
  logic                 sym_end;
  logic                 busy;
  logic                 peak_valid;
  logic [12:0]          peak_idx;
  logic [MW-1:0]        peak_val;
  logic [LOG2_NSYM:0]   sym_cnt;
  logic                 done;
  logic [12:0]          offset;

  modport master (
    output start, idx, metric_valid, metric, sym_end,
    input  busy, peak_valid, peak_idx, peak_val, sym_cnt, done, offset
  );

  modport slave (
    input  start, idx, metric_valid, metric, sym_end,
    output busy, peak_valid, peak_idx, peak_val, sym_cnt, done, offset
  );
endinterface

// File: rtl/peak_offset_tracker.sv
// Tracks the peak timing metric per OFDM symbol over 2^LOG2_NSYM symbols and produces a timing offset.
// Define PEAK_AVG_EN to average the per-symbol peak indices; otherwise the last symbol's peak is used.
module peak_offset_tracker #(
  parameter int MW        = 24,
  parameter int LOG2_NSYM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  peak_offset_tracker_if.slave  bus
);
  localparam int NSYM = 1 << LOG2_NSYM;

  typedef enum logic [1:0] {IDLE, SEARCH, REPORT, FINISH} state_t;

  state_t               state_q, state_d;
  logic [MW-1:0]        max_q, max_d;
  logic [12:0]          max_idx_q, max_idx_d;
  logic                 seen_q, seen_d;
  logic [12:0]          peak_idx_q, peak_idx_d;
  logic [MW-1:0]        peak_val_q, peak_val_d;
  logic [LOG2_NSYM:0]   sym_cnt_q, sym_cnt_d;
  logic [12:0]          offset_q, offset_d;
  logic                 take;
  logic [MW-1:0]        cand_val;
  logic [12:0]          cand_idx;
`ifdef PEAK_AVG_EN
  logic [LOG2_NSYM+12:0] acc_q, acc_d;
`endif

  // seen_q forces the first valid metric of a symbol to load, even a zero.
  assign take     = bus.metric_valid && (!seen_q || (bus.metric > max_q));
  assign cand_val = take ? bus.metric : max_q;
  assign cand_idx = take ? bus.idx : max_idx_q;

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    seen_d     = seen_q;
    peak_idx_d = peak_idx_q;
    peak_val_d = peak_val_q;
    sym_cnt_d  = sym_cnt_q;
    offset_d   = offset_q;
`ifdef PEAK_AVG_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SEARCH;
          max_d     = '0;
          max_idx_d = '0;
          seen_d    = 1'b0;
          sym_cnt_d = '0;
`ifdef PEAK_AVG_EN
          acc_d     = '0;
`endif
        end
      end
      SEARCH: begin
        if (bus.sym_end) begin
          state_d    = REPORT;
          peak_idx_d = cand_idx;
          peak_val_d = cand_val;
          sym_cnt_d  = sym_cnt_q + 1'b1;
          max_d      = '0;
          max_idx_d  = '0;
          seen_d     = 1'b0;
`ifdef PEAK_AVG_EN
          acc_d      = acc_q + (LOG2_NSYM+13)'(cand_idx);
`endif
        end else begin
          max_d     = cand_val;
          max_idx_d = cand_idx;
          seen_d    = seen_q | bus.metric_valid;
        end
      end
      REPORT: begin
        // The max was cleared on entry, so a metric here opens the next symbol.
        max_d     = cand_val;
        max_idx_d = cand_idx;
        seen_d    = seen_q | bus.metric_valid;
        if (sym_cnt_q == (LOG2_NSYM+1)'(NSYM)) begin
          state_d  = FINISH;
`ifdef PEAK_AVG_EN
          offset_d = acc_q[LOG2_NSYM +: 13];
`else
          offset_d = peak_idx_q;
`endif
        end else begin
          state_d = SEARCH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      max_q      <= '0;
      max_idx_q  <= '0;
      seen_q     <= 1'b0;
      peak_idx_q <= '0;
      peak_val_q <= '0;
      sym_cnt_q  <= '0;
      offset_q   <= '0;
`ifdef PEAK_AVG_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      seen_q     <= seen_d;
      peak_idx_q <= peak_idx_d;
      peak_val_q <= peak_val_d;
      sym_cnt_q  <= sym_cnt_d;
      offset_q   <= offset_d;
`ifdef PEAK_AVG_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign bus.busy       = (state_q == SEARCH) || (state_q == REPORT);
  assign bus.peak_valid = (state_q == REPORT);
  assign bus.done       = (state_q == FINISH);
  assign bus.peak_idx   = peak_idx_q;
  assign bus.peak_val   = peak_val_q;
  assign bus.sym_cnt    = sym_cnt_q;
  assign bus.offset     = offset_q;
endmodule
